immediate_reader: RTL and testbench



---
 rtl/immediate_reader_pkg.sv | 13 +
 rtl/immediate_reader.sv | 114 +++++++++++
 tb/tb_immediate_reader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/immediate_reader_pkg.sv
// CPU-wide shared types for the instruction-stream front end.
package immediate_reader_pkg;

  typedef logic [7:0]  instr_byte_t;
  typedef logic [15:0] imm16_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ_LO = 2'd1,
    READ_HI = 2'd2
  } imm_state_e;

endpackage

// File: rtl/immediate_reader.sv
// Pops 1 or 2 bytes from the show-ahead instruction FIFO and assembles a
// little-endian immediate. Optional macro IMM_SIGN_EXTEND_EN enables 8-bit sign extension.
module immediate_reader
  import immediate_reader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_8bit,
  input  logic        sign_extend,
  input  logic        flush,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic        busy,
  output logic        complete,
  output logic [15:0] immediate
);

  imm_state_e  state_q, state_d;
  instr_byte_t low_q, low_d;
  imm16_t      imm_q, imm_d;
  logic        is8_q, is8_d;
  logic        complete_q, complete_d;

`ifdef IMM_SIGN_EXTEND_EN
  logic        sext_q, sext_d;
`else
  logic        unused_sign_extend;
  assign unused_sign_extend = sign_extend;
`endif

  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    imm_d      = imm_q;
    is8_d      = is8_q;
    complete_d = 1'b0;
    fifo_rd_en = 1'b0;
`ifdef IMM_SIGN_EXTEND_EN
    sext_d     = sext_q;
`endif
    // Flush outranks both start and a pending pop; the partial byte is dropped.
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          is8_d   = is_8bit;
`ifdef IMM_SIGN_EXTEND_EN
          sext_d  = sign_extend;
`endif
          state_d = READ_LO;
        end
      end
      READ_LO: begin
        if (flush) begin
          state_d = IDLE;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          low_d      = fifo_rd_data;
          if (is8_q) begin
`ifdef IMM_SIGN_EXTEND_EN
            imm_d = sext_q ? {{8{fifo_rd_data[7]}}, fifo_rd_data}
                           : {8'h00, fifo_rd_data};
`else
            imm_d = {8'h00, fifo_rd_data};
`endif
            complete_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = READ_HI;
          end
        end
      end
      READ_HI: begin
        if (flush) begin
          state_d = IDLE;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          imm_d      = {fifo_rd_data, low_q};
          complete_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      low_q      <= '0;
      imm_q      <= '0;
      is8_q      <= 1'b0;
      complete_q <= 1'b0;
`ifdef IMM_SIGN_EXTEND_EN
      sext_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      low_q      <= low_d;
      imm_q      <= imm_d;
      is8_q      <= is8_d;
      complete_q <= complete_d;
`ifdef IMM_SIGN_EXTEND_EN
      sext_q     <= sext_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign complete  = complete_q;
  assign immediate = imm_q;

endmodule

// File: tb/tb_immediate_reader.sv
// Self-checking bench for immediate_reader: directed cases plus randomized
// reads against a byte-schedule reference model.
module tb_immediate_reader;

`ifdef IMM_SIGN_EXTEND_EN
  localparam bit SEXT_EN = 1'b1;
`else
  localparam bit SEXT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, start, is_8bit, sign_extend, flush;
  logic        fifo_rd_en, fifo_empty, busy, complete;
  logic [7:0]  fifo_rd_data;
  logic [15:0] immediate;

  always #5 clk = ~clk;

  immediate_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .is_8bit      (is_8bit),
    .sign_extend  (sign_extend),
    .flush        (flush),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .busy         (busy),
    .complete     (complete),
    .immediate    (immediate)
  );

  // Show-ahead FIFO model; flush and reset empty it like the prefetcher's FIFO.
  logic [7:0] mem [0:63];
  logic [5:0] wr_ptr = '0;
  logic [5:0] rd_ptr = '0;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = mem[rd_ptr];

  always @(posedge clk) begin
    if (!reset_n || flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en)   rd_ptr <= rd_ptr + 6'd1;
  end

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_imm = '0;

  task automatic push(input int b);
    mem[wr_ptr] = 8'(b);
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_imm(input bit is8, input bit sx, input int b0, input int b1);
    if (!is8) return 16'(b1 * 256 + b0);
    if (SEXT_EN && sx && b0 >= 128) return 16'(b0 + 65280);
    return 16'(b0);
  endfunction

  // One read: byte0 pushed g0 cycles after start, byte1 at g1 (g1 >= g0).
  // A byte pushed at cycle k is poppable on edge k+1; first pop edge is 2.
  task automatic run_read(input bit is8, input bit sx, input int b0, input int b1,
                          input int g0, input int g1);
    int p0, p1, tc;
    logic [15:0] exp;
    p0  = (g0 + 1 > 2) ? g0 + 1 : 2;
    p1  = (g1 + 1 > p0 + 1) ? g1 + 1 : p0 + 1;
    tc  = is8 ? p0 : p1;
    exp = ref_imm(is8, sx, b0, b1);
    start = 1'b1; is_8bit = is8; sign_extend = sx;
    if (g0 == 0) push(b0);
    if (!is8 && g1 == 0) push(b1);
    #1;
    chk("start_rd_en", 16'(fifo_rd_en), 16'(0));
    chk("start_busy", 16'(busy), 16'(0));
    for (int t = 1; t <= tc + 1; t++) begin
      step();
      start       = (t < tc) ? 1'($urandom) : 1'b0;
      is_8bit     = 1'($urandom);
      sign_extend = 1'($urandom);
      if (t == g0) push(b0);
      if (!is8 && t == g1) push(b1);
      #1;
      chk("busy", 16'(busy), 16'(t < tc));
      chk("complete", 16'(complete), 16'(t == tc));
      chk("rd_en", 16'(fifo_rd_en), 16'((t == p0 - 1) || (!is8 && t == p1 - 1)));
      chk("immediate", immediate, (t >= tc) ? exp : exp_imm);
    end
    exp_imm = exp;
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; is_8bit = 1'b0; sign_extend = 1'b0; flush = 1'b0;
    step(); step();
    #1;
    chk("rst_busy", 16'(busy), 16'(0));
    chk("rst_complete", 16'(complete), 16'(0));
    chk("rst_rd_en", 16'(fifo_rd_en), 16'(0));
    chk("rst_immediate", immediate, 16'h0000);
    reset_n = 1'b1;
    step();

    // Spec examples: 8-bit, 16-bit, starved FIFO, 0x80 with sign_extend.
    run_read(1'b1, 1'b0, 'hA5, 0, 0, 0);
    chk("ex_8bit", immediate, 16'h00A5);
    run_read(1'b0, 1'b0, 'h34, 'h12, 0, 0);
    chk("ex_16bit", immediate, 16'h1234);
    run_read(1'b0, 1'b0, 'hCD, 'hAB, 3, 8);
    chk("ex_starved", immediate, 16'hABCD);
    run_read(1'b1, 1'b1, 'h80, 0, 0, 0);
    chk("ex_sext", immediate, SEXT_EN ? 16'hFF80 : 16'h0080);

    // Start accepted in the complete cycle.
    push('h3C);
    start = 1'b1; is_8bit = 1'b1;
    step(); start = 1'b0;
    step();
    push('h78); push('h56);
    start = 1'b1; is_8bit = 1'b0;
    #1;
    chk("b2b_complete", 16'(complete), 16'(1));
    chk("b2b_imm8", immediate, 16'h003C);
    chk("b2b_busy", 16'(busy), 16'(0));
    step(); start = 1'b0; #1;
    chk("b2b_busy2", 16'(busy), 16'(1));
    chk("b2b_rd_lo", 16'(fifo_rd_en), 16'(1));
    step(); #1;
    chk("b2b_rd_hi", 16'(fifo_rd_en), 16'(1));
    step(); #1;
    chk("b2b_complete2", 16'(complete), 16'(1));
    chk("b2b_imm16", immediate, 16'h5678);
    exp_imm = 16'h5678;
    step();

    // start together with flush stays idle.
    push('h11);
    start = 1'b1; flush = 1'b1; is_8bit = 1'b1;
    step(); start = 1'b0; flush = 1'b0; #1;
    chk("sf_busy", 16'(busy), 16'(0));
    chk("sf_rd_en", 16'(fifo_rd_en), 16'(0));
    step(); #1;
    chk("sf_complete", 16'(complete), 16'(0));
    chk("sf_imm", immediate, exp_imm);

    // Flush in READ_HI with data present.
    push('h9A); push('hBC);
    start = 1'b1; is_8bit = 1'b0;
    step(); start = 1'b0; #1;
    chk("fl_rd_lo", 16'(fifo_rd_en), 16'(1));
    step(); flush = 1'b1; #1;
    chk("fl_rd_en", 16'(fifo_rd_en), 16'(0));
    chk("fl_busy_hi", 16'(busy), 16'(1));
    step(); flush = 1'b0; #1;
    chk("fl_busy", 16'(busy), 16'(0));
    chk("fl_complete", 16'(complete), 16'(0));
    chk("fl_imm", immediate, exp_imm);
    step(); #1;
    chk("fl_complete2", 16'(complete), 16'(0));
    run_read(1'b1, 1'b0, 'h5A, 0, 0, 0);
    chk("fl_after", immediate, 16'h005A);

    // Randomized reads with random byte arrival gaps.
    for (int i = 0; i < 40; i++) begin
      int g0;
      g0 = int'($urandom_range(0, 3));
      run_read(1'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), g0, g0 + int'($urandom_range(0, 3)));
    end

    // Reset mid-read.
    push('hEE);
    start = 1'b1; is_8bit = 1'b0;
    step(); start = 1'b0;
    step(); reset_n = 1'b0;
    step(); #1;
    chk("mrst_busy", 16'(busy), 16'(0));
    chk("mrst_complete", 16'(complete), 16'(0));
    chk("mrst_rd_en", 16'(fifo_rd_en), 16'(0));
    chk("mrst_imm", immediate, 16'h0000);
    reset_n = 1'b1;
    step(); #1;
    chk("mrst_complete2", 16'(complete), 16'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
